// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// OpALU / ALUSrcB / PCSource codes (OpALU codes are also consumed by ULAControl).
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_TRAP   = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic [1:0] op_alu;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       instr_done;
      logic       mem_err;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
   endfunction

   // Illegal opcodes fall through to FETCH; the trap build overrides this.
   function automatic state_e decode_target(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW: return S_MEMADR;
         OP_RTYPE:     return S_EXEC;
         OP_BEQ:       return S_BRANCH;
         OP_J:         return S_JUMP;
         OP_ADDI:      return S_ADDIEX;
         default:      return S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts mem_ready-low cycles in a wait state and flags the
// cycle where the count reaches MEM_TIMEOUT with memory still not ready (0 = never).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic mem_ready,
   input  logic clear,
   output logic timeout
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam int LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (active && !mem_ready) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // The limit is hit in the cycle whose increment would reach MEM_TIMEOUT.
   assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready &&
                    (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: Moore strobes per state, mem_ready-gated fetch/load/store,
// wait timeout via mem_wait_timer. ILLEGAL_TRAP_EN adds a sticky TRAP state and illegal_op.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int STATE_W     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic [1:0]         OpALU,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic               pc_en,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               instr_done,
   output logic               mem_err,
   output logic [STATE_W-1:0] state
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic               illegal_op
`endif
);

   state_e state_q;
   state_e state_d;
   ctrl_t  c;
   ctrl_t  c_out;
   logic   illegal_d;
   logic   wait_active;
   logic   timeout;
   logic   clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   assign wait_active = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);
   // Any state change (or a timeout re-entering FETCH) counts as a fresh entry.
   assign clear = (state_d != state_q) || timeout;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .active    (wait_active),
      .mem_ready (mem_ready),
      .clear     (clear),
      .timeout   (timeout)
   );

   always_comb begin
      c         = '0;
      illegal_d = 1'b0;
      state_d   = state_q;
      case (state_q)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.op_alu    = ALUOP_ADD;
            c.pc_source = PCSRC_ALU;
            if (timeout) begin
               c.mem_err = 1'b1;
               state_d   = S_FETCH;
            end else if (mem_ready) begin
               c.ir_write = 1'b1;
               c.pc_write = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM_SH2;
            c.op_alu    = ALUOP_ADD;
            state_d     = decode_target(opcode);
`ifdef ILLEGAL_TRAP_EN
            if (!is_legal_op(opcode)) begin
               state_d = S_TRAP;
            end
`endif
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.op_alu    = ALUOP_ADD;
            state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
            if (timeout) begin
               c.mem_err = 1'b1;
               state_d   = S_FETCH;
            end else if (mem_ready) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.instr_done = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEMWR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
            if (timeout) begin
               c.mem_err = 1'b1;
               state_d   = S_FETCH;
            end else if (mem_ready) begin
               c.instr_done = 1'b1;
               state_d      = S_FETCH;
            end
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_REG;
            c.op_alu    = ALUOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = 1'b1;
            c.instr_done = 1'b1;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_REG;
            c.op_alu        = ALUOP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
            c.instr_done    = 1'b1;
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PCSRC_JUMP;
            c.instr_done = 1'b1;
            state_d      = S_FETCH;
         end
         S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.op_alu    = ALUOP_ADD;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
            state_d      = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
         end
`endif
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Reset forces every output low combinationally, even before the first edge.
   assign c_out = rst_n ? c : '0;

   assign OpALU      = c_out.op_alu;
   assign ALUSrcA    = c_out.alu_src_a;
   assign ALUSrcB    = c_out.alu_src_b;
   assign PCSource   = c_out.pc_source;
   assign pc_en      = c_out.pc_write | (c_out.pc_write_cond & zero);
   assign IorD       = c_out.iord;
   assign MemRead    = c_out.mem_read;
   assign MemWrite   = c_out.mem_write;
   assign IRWrite    = c_out.ir_write;
   assign RegDst     = c_out.reg_dst;
   assign MemtoReg   = c_out.mem_to_reg;
   assign RegWrite   = c_out.reg_write;
   assign instr_done = c_out.instr_done;
   assign mem_err    = c_out.mem_err;
   assign state      = STATE_W'(state_q);

`ifdef ILLEGAL_TRAP_EN
   assign illegal_op = rst_n & illegal_d;
`else
   logic unused_illegal;
   assign unused_illegal = illegal_d;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT = 4): instruction traces,
// memory waits, timeout, illegal opcode and asynchronous reset mid-instruction.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic [1:0] OpALU;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSource;
   logic       pc_en;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       instr_done;
   logic       mem_err;
   logic [3:0] state;
`ifdef ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int cyc = 0;
   int t0 = 0;

   multicycle_control #(
      .MEM_TIMEOUT (4),
      .STATE_W     (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .OpALU      (OpALU),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .PCSource   (PCSource),
      .pc_en      (pc_en),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .instr_done (instr_done),
      .mem_err    (mem_err),
      .state      (state)
`ifdef ILLEGAL_TRAP_EN
      ,
      .illegal_op (illegal_op)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (instr_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive mem_ready for the current cycle, then sample at the falling edge.
   task automatic at(input string tag, input logic [3:0] st, input logic mr);
      mem_ready = mr;
      @(negedge clk);
      check({tag, "_state"}, 32'(state), 32'(st));
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_memread", 32'(MemRead), 32'd0);
      check("rst_irwrite", 32'(IRWrite), 32'd0);
      check("rst_pc_en", 32'(pc_en), 32'd0);
      adv();
      rst_n = 1'b1;

      // R-type: 0,1,6,7
      at("r_fetch", 4'd0, 1'b1);
      check("r_fetch_irw", 32'(IRWrite), 32'd1);
      check("r_fetch_srcb", 32'(ALUSrcB), 32'd1);
      check("r_fetch_pc_en", 32'(pc_en), 32'd1);
      adv();
      at("r_dec", 4'd1, 1'b1);
      check("r_dec_srcb", 32'(ALUSrcB), 32'd3);
      adv();
      at("r_exec", 4'd6, 1'b1);
      check("r_exec_opalu", 32'(OpALU), 32'd2);
      check("r_exec_srca", 32'(ALUSrcA), 32'd1);
      adv();
      at("r_wb", 4'd7, 1'b1);
      check("r_wb_regwrite", 32'(RegWrite), 32'd1);
      check("r_wb_regdst", 32'(RegDst), 32'd1);
      adv();
      check("r_done_cnt", 32'(done_cnt), 32'd1);

      // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4
      opcode = 6'b100011;
      at("lw_fetch", 4'd0, 1'b1);
      t0 = cyc;
      adv();
      at("lw_dec", 4'd1, 1'b1); adv();
      at("lw_adr", 4'd2, 1'b1);
      check("lw_adr_srcb", 32'(ALUSrcB), 32'd2);
      adv();
      at("lw_rd_a", 4'd3, 1'b0);
      check("lw_rd_iord", 32'(IorD), 32'd1);
      check("lw_rd_memread", 32'(MemRead), 32'd1);
      adv();
      at("lw_rd_b", 4'd3, 1'b0); adv();
      at("lw_rd_c", 4'd3, 1'b1); adv();
      at("lw_wb", 4'd4, 1'b1);
      check("lw_wb_memtoreg", 32'(MemtoReg), 32'd1);
      check("lw_wb_regwrite", 32'(RegWrite), 32'd1);
      check("lw_cycles", 32'(cyc - t0 + 1), 32'd7);
      adv();
      check("lw_done_cnt", 32'(done_cnt), 32'd2);

      // beq taken then not taken
      opcode = 6'b000100;
      for (int z = 1; z >= 0; z--) begin
         zero = z[0];
         at("beq_fetch", 4'd0, 1'b1); adv();
         at("beq_dec", 4'd1, 1'b1); adv();
         at("beq_br", 4'd8, 1'b1);
         check("beq_opalu", 32'(OpALU), 32'd1);
         check("beq_pcsource", 32'(PCSource), 32'd1);
         check("beq_pc_en", 32'(pc_en), 32'(z));
         adv();
      end

      // jump
      opcode = 6'b000010; zero = 1'b0;
      at("j_fetch", 4'd0, 1'b1); adv();
      at("j_dec", 4'd1, 1'b1); adv();
      at("j_jump", 4'd9, 1'b1);
      check("j_pcsource", 32'(PCSource), 32'd2);
      check("j_pc_en", 32'(pc_en), 32'd1);
      adv();
      check("j_done_cnt", 32'(done_cnt), 32'd5);

      // FETCH timeout after 4 low cycles, then limit-cycle completion, then addi
      opcode = 6'b001000;
      for (int i = 0; i < 4; i++) begin
         at("to_fetch", 4'd0, 1'b0);
         check("to_mem_err", 32'(mem_err), 32'(i == 3));
         check("to_irwrite", 32'(IRWrite), 32'd0);
         adv();
      end
      for (int i = 0; i < 3; i++) begin
         at("to2_fetch", 4'd0, 1'b0);
         check("to2_mem_err", 32'(mem_err), 32'd0);
         adv();
      end
      at("edge_fetch", 4'd0, 1'b1);
      check("edge_irwrite", 32'(IRWrite), 32'd1);
      check("edge_mem_err", 32'(mem_err), 32'd0);
      adv();
      at("addi_dec", 4'd1, 1'b1); adv();
      at("addi_ex", 4'd10, 1'b1);
      check("addi_ex_srcb", 32'(ALUSrcB), 32'd2);
      check("addi_ex_srca", 32'(ALUSrcA), 32'd1);
      adv();
      at("addi_wb", 4'd11, 1'b1);
      check("addi_wb_regwrite", 32'(RegWrite), 32'd1);
      check("addi_wb_regdst", 32'(RegDst), 32'd0);
      adv();
      check("addi_done_cnt", 32'(done_cnt), 32'd6);

      // sw with one wait cycle in MEMWR
      opcode = 6'b101011;
      at("sw_fetch", 4'd0, 1'b1); adv();
      at("sw_dec", 4'd1, 1'b1); adv();
      at("sw_adr", 4'd2, 1'b1); adv();
      at("sw_wr_a", 4'd5, 1'b0);
      check("sw_wr_memwrite", 32'(MemWrite), 32'd1);
      check("sw_wr_wait_done", 32'(instr_done), 32'd0);
      adv();
      at("sw_wr_b", 4'd5, 1'b1);
      check("sw_wr_done", 32'(instr_done), 32'd1);
      adv();
      check("sw_done_cnt", 32'(done_cnt), 32'd7);

      // illegal opcode
      opcode = 6'b111111;
      at("ill_fetch", 4'd0, 1'b1); adv();
      at("ill_dec", 4'd1, 1'b1);
      check("ill_dec_done", 32'(instr_done), 32'd0);
      adv();
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         at("ill_trap", 4'd12, 1'b1);
         check("ill_trap_flag", 32'(illegal_op), 32'd1);
         check("ill_trap_memread", 32'(MemRead), 32'd0);
         adv();
      end
      rst_n = 1'b0;
      at("ill_rst", 4'd0, 1'b1);
      check("ill_rst_flag", 32'(illegal_op), 32'd0);
      adv();
      rst_n = 1'b1;
`endif
      check("ill_done_cnt", 32'(done_cnt), 32'd7);

      // Reset asserted mid-MEMRD
      opcode = 6'b100011;
      at("rm_fetch", 4'd0, 1'b1); adv();
      at("rm_dec", 4'd1, 1'b1); adv();
      at("rm_adr", 4'd2, 1'b1); adv();
      at("rm_rd", 4'd3, 1'b0); adv();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         at("rm_rst", 4'd0, 1'b0);
         check("rm_rst_memread", 32'(MemRead), 32'd0);
         check("rm_rst_iord", 32'(IorD), 32'd0);
         check("rm_rst_regwrite", 32'(RegWrite), 32'd0);
         adv();
      end
      rst_n = 1'b1;
      at("rm_resume", 4'd0, 1'b1);
      check("rm_resume_memread", 32'(MemRead), 32'd1);
      check("rm_resume_irwrite", 32'(IRWrite), 32'd1);
      adv();
      at("rm_dec2", 4'd1, 1'b1);
      adv();
      check("rm_done_cnt", 32'(done_cnt), 32'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
